// File: rtl/eth_rx_ctrl.sv
// rtl/eth_rx_ctrl.sv - RMII receive frame sequencer: preamble/SFD strip, dibit forwarding, CRC verdict, status strobe
module eth_rx_ctrl #(
  parameter int PRE_MIN     = 28,
  parameter int MIN_DIBITS  = 256,
  parameter int MAX_DIBITS  = 6072,
  parameter int CRC_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        crc_axiiv,
  output logic [1:0]  crc_axiid,
  input  logic        crc_done,
  input  logic        crc_kill,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [4:0]  frame_err,
  output logic [15:0] frame_len,
  output logic        busy
);

  localparam int PW = $clog2(PRE_MIN + 1);
  localparam int TW = $clog2(CRC_TIMEOUT + 1);
  localparam logic [PW-1:0] PRE_L    = PW'(PRE_MIN);
  localparam logic [12:0]   MIN_L    = 13'(MIN_DIBITS);
  localparam logic [12:0]   MAX_L    = 13'(MAX_DIBITS);
  localparam logic [TW-1:0] TMO_LAST = TW'(CRC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_WAIT, S_STATUS
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [12:0]   len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          oversize_q, oversize_d;
  logic          crc_fail_q, crc_fail_d;
  logic          timeout_q, timeout_d;
  logic          fwd;
  logic [4:0]    err_d;

  logic          axiov_q;
  logic [1:0]    axiod_q;
  logic          done_q, ok_q;
  logic [4:0]    err_q;
  logic [15:0]   flen_q;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    oversize_d = oversize_q;
    crc_fail_d = crc_fail_q;
    timeout_d  = timeout_q;
    fwd        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (crsdv && rxd == 2'b01) begin
          state_d   = S_PRE;
          pre_cnt_d = PW'(1);
        end
      end
      S_PRE: begin
        if (crsdv && rxd == 2'b01) begin
          if (pre_cnt_q < PRE_L) pre_cnt_d = pre_cnt_q + PW'(1);
        end else if (crsdv && rxd == 2'b11 && pre_cnt_q >= PRE_L) begin
          state_d    = S_DATA;
          len_d      = '0;
          oversize_d = 1'b0;
          crc_fail_d = 1'b0;
          timeout_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (crsdv) begin
          if (len_q < MAX_L) begin
            fwd   = 1'b1;
            len_d = len_q + 13'd1;
          end else begin
            oversize_d = 1'b1;
          end
        end else if (len_q == 13'd0) begin
          // Checker never saw a dibit, so there is no verdict to wait for.
          state_d    = S_STATUS;
          crc_fail_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end
      end
      S_WAIT: begin
        if (crc_done) begin
          crc_fail_d = crc_kill;
          state_d    = S_STATUS;
        end else if (tmo_q == TMO_LAST) begin
          timeout_d  = 1'b1;
          crc_fail_d = 1'b1;
          state_d    = S_STATUS;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_STATUS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    err_d = {timeout_d, |len_q[1:0], oversize_d, (len_q < MIN_L), crc_fail_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
      oversize_q <= 1'b0;
      crc_fail_q <= 1'b0;
      timeout_q  <= 1'b0;
      axiov_q    <= 1'b0;
      axiod_q    <= 2'b00;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= '0;
      flen_q     <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
      oversize_q <= oversize_d;
      crc_fail_q <= crc_fail_d;
      timeout_q  <= timeout_d;
      axiov_q    <= fwd;
      axiod_q    <= fwd ? rxd : 2'b00;
      done_q     <= (state_d == S_STATUS);
      // Status fields are loaded together with the strobe and held until the next frame.
      if (state_d == S_STATUS) begin
        ok_q   <= (err_d == 5'd0);
        err_q  <= err_d;
        flen_q <= {5'd0, len_q[12:2]};
      end
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign crc_axiiv  = axiov_q;
  assign crc_axiid  = axiod_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign frame_err  = err_q;
  assign frame_len  = flen_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb/tb_eth_rx_ctrl.sv - randomized frame bench for eth_rx_ctrl with a length/flag reference model
module tb_eth_rx_ctrl;

  localparam int PRE_MIN     = 28;
  localparam int MIN_DIBITS  = 256;
  localparam int MAX_DIBITS  = 6072;
  localparam int CRC_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst, crsdv, crc_done, crc_kill;
  logic [1:0]  rxd;
  logic        axiov, crc_axiiv, frame_done, frame_ok, busy;
  logic [1:0]  axiod, crc_axiid;
  logic [4:0]  frame_err;
  logic [15:0] frame_len;

  eth_rx_ctrl dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .axiov(axiov), .axiod(axiod), .crc_axiiv(crc_axiiv), .crc_axiid(crc_axiid),
    .crc_done(crc_done), .crc_kill(crc_kill),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_err(frame_err),
    .frame_len(frame_len), .busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [1:0]  tx_q[$];
  logic [1:0]  rx_q[$];
  int          done_cnt = 0, mirror_bad = 0, first_v_cyc = -1, done_cyc = 0;
  logic        got_ok;
  logic [4:0]  got_err;
  logic [15:0] got_len;
  bit          kill_flag = 1'b0, stall_flag = 1'b0;
  int          drive0_cyc, fall_cyc, got_done, data_bad;

  // Monitor plus a behavioural CRC checker: verdict two cycles after the stream ends.
  initial begin : monitor_and_checker
    logic prev_v;
    bit   fell;
    prev_v   = 1'b0;
    fell     = 1'b0;
    crc_done = 1'b0;
    crc_kill = 1'b0;
    forever begin
      @(negedge clk);
      if (crc_axiiv !== axiov || crc_axiid !== axiod) mirror_bad++;
      if (axiov === 1'b1) begin
        rx_q.push_back(axiod);
        if (first_v_cyc < 0) first_v_cyc = cyc;
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        got_ok   = frame_ok;
        got_err  = frame_err;
        got_len  = frame_len;
      end
      if (rst) begin
        crc_done = 1'b0;
        crc_kill = 1'b0;
        fell     = 1'b0;
      end else if (fell) begin
        fell = 1'b0;
        if (!stall_flag) begin
          crc_done = 1'b1;
          crc_kill = kill_flag;
        end
      end
      if (axiov === 1'b1 && !prev_v) crc_done = 1'b0;
      if (axiov !== 1'b1 && prev_v) fell = 1'b1;
      prev_v = (axiov === 1'b1);
    end
  end

  function automatic void model(input int npre, input int nd, input bit bad, input bit stall,
                                output bit acc, output int fwd, output logic [4:0] err,
                                output logic [15:0] len);
    acc    = (npre >= PRE_MIN);
    fwd    = !acc ? 0 : (nd > MAX_DIBITS) ? MAX_DIBITS : nd;
    err[0] = (fwd == 0) || stall || bad;
    err[1] = (fwd < MIN_DIBITS);
    err[2] = (nd > MAX_DIBITS);
    err[3] = (fwd % 4) != 0;
    err[4] = stall && (fwd > 0);
    len    = 16'(fwd / 4);
  endfunction

  task automatic send_frame(input int npre, input int nd, input bit bad, input bit stall);
    int base;
    logic [1:0] d;
    tx_q.delete();
    rx_q.delete();
    first_v_cyc = -1;
    kill_flag   = bad;
    stall_flag  = stall;
    base        = done_cnt;
    for (int i = 0; i < npre; i++) begin
      @(negedge clk); crsdv = 1'b1; rxd = 2'b01;
    end
    @(negedge clk); crsdv = 1'b1; rxd = 2'b11;
    for (int i = 0; i < nd; i++) begin
      @(negedge clk);
      d = 2'($urandom);
      rxd = d;
      tx_q.push_back(d);
      if (i == 0) drive0_cyc = cyc;
    end
    @(negedge clk); crsdv = 1'b0; rxd = 2'b00; fall_cyc = cyc;
    for (int w = 0; w < 40 && done_cnt == base; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    got_done = done_cnt - base;
    data_bad = 0;
    for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++)
      if (rx_q[i] !== tx_q[i]) data_bad++;
  endtask

  task automatic test_reset;
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (axiov !== 1'b0 || crc_axiiv !== 1'b0 || axiod !== 2'b00) begin
      errors++; $display("FAIL reset_stream got v=%b d=%b exp v=0 d=00", axiov, axiod);
    end
    checks++;
    if (frame_done !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 5'd0 || frame_len !== 16'd0) begin
      errors++; $display("FAIL reset_status got done=%b ok=%b err=%b len=%0d exp all 0",
                         frame_done, frame_ok, frame_err, frame_len);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame;
    bit acc; int fwd; logic [4:0] e; logic [15:0] l;
    model(31, 256, 1'b0, 1'b0, acc, fwd, e, l);
    send_frame(31, 256, 1'b0, 1'b0);
    checks++;
    if (got_done !== 1) begin errors++; $display("FAIL good_done_count got %0d exp 1", got_done); end
    checks++;
    if (got_ok !== (e == 5'd0)) begin errors++; $display("FAIL good_ok got %b exp %b", got_ok, (e == 5'd0)); end
    checks++;
    if (got_err !== e) begin errors++; $display("FAIL good_err got %b exp %b", got_err, e); end
    checks++;
    if (got_len !== l) begin errors++; $display("FAIL good_len got %0d exp %0d", got_len, l); end
    checks++;
    if (rx_q.size() != fwd) begin errors++; $display("FAIL good_fwd_count got %0d exp %0d", rx_q.size(), fwd); end
    checks++;
    if (data_bad != 0) begin errors++; $display("FAIL good_data got %0d bad dibits exp 0", data_bad); end
    checks++;
    if (first_v_cyc - drive0_cyc != 1) begin
      errors++; $display("FAIL good_lag got %0d exp 1", first_v_cyc - drive0_cyc);
    end
    checks++;
    if (frame_ok !== 1'b1 || frame_len !== l) begin
      errors++; $display("FAIL good_hold got ok=%b len=%0d exp ok=1 len=%0d", frame_ok, frame_len, l);
    end
  endtask

  task automatic test_crc_error;
    bit acc; int fwd; logic [4:0] e; logic [15:0] l;
    model(31, 256, 1'b1, 1'b0, acc, fwd, e, l);
    send_frame(31, 256, 1'b1, 1'b0);
    checks++;
    if (got_done !== 1 || got_ok !== 1'b0 || got_err !== e || got_len !== l) begin
      errors++; $display("FAIL crc_error got n=%0d ok=%b err=%b len=%0d exp n=1 ok=0 err=%b len=%0d",
                         got_done, got_ok, got_err, got_len, e, l);
    end
  endtask

  task automatic test_short_preamble;
    bit acc; int fwd; logic [4:0] e; logic [15:0] l; int nd;
    send_frame(20, 100, 1'b0, 1'b0);
    checks++;
    if (got_done !== 0 || rx_q.size() != 0) begin
      errors++; $display("FAIL short_pre got done=%0d fwd=%0d exp 0 0", got_done, rx_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL short_pre_busy got %b exp 0", busy); end
    nd = $urandom_range(400, 256);
    model(PRE_MIN, nd, 1'b0, 1'b0, acc, fwd, e, l);
    send_frame(PRE_MIN, nd, 1'b0, 1'b0);
    checks++;
    if (got_done !== 1 || got_err !== e || got_len !== l || got_ok !== (e == 5'd0)) begin
      errors++; $display("FAIL after_short got n=%0d ok=%b err=%b len=%0d exp n=1 err=%b len=%0d",
                         got_done, got_ok, got_err, got_len, e, l);
    end
  endtask

  task automatic test_mid_reset;
    int base;
    base = done_cnt;
    for (int i = 0; i < 30; i++) begin @(negedge clk); crsdv = 1'b1; rxd = 2'b01; end
    @(negedge clk); rxd = 2'b11;
    for (int i = 0; i < 50; i++) begin @(negedge clk); rxd = 2'($urandom); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (axiov !== 1'b0 || crc_axiiv !== 1'b0 || frame_done !== 1'b0 || frame_ok !== 1'b0 ||
        frame_err !== 5'd0 || frame_len !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b done=%b ok=%b err=%b len=%0d busy=%b exp all 0",
                         axiov, frame_done, frame_ok, frame_err, frame_len, busy);
    end
    rst = 1'b0; crsdv = 1'b0; rxd = 2'b00;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != base) begin errors++; $display("FAIL mid_reset_done got %0d exp 0", done_cnt - base); end
  endtask

  task automatic test_oversize_and_empty;
    bit acc; int fwd; logic [4:0] e; logic [15:0] l;
    model(31, 6400, 1'b0, 1'b0, acc, fwd, e, l);
    send_frame(31, 6400, 1'b0, 1'b0);
    checks++;
    if (rx_q.size() != fwd) begin errors++; $display("FAIL oversize_fwd got %0d exp %0d", rx_q.size(), fwd); end
    checks++;
    if (got_done !== 1 || got_err !== e || got_len !== l || got_ok !== 1'b0) begin
      errors++; $display("FAIL oversize got n=%0d ok=%b err=%b len=%0d exp n=1 ok=0 err=%b len=%0d",
                         got_done, got_ok, got_err, got_len, e, l);
    end
    checks++;
    if (data_bad != 0) begin errors++; $display("FAIL oversize_data got %0d bad exp 0", data_bad); end
    model(31, 0, 1'b0, 1'b0, acc, fwd, e, l);
    send_frame(31, 0, 1'b0, 1'b0);
    checks++;
    if (got_done !== 1 || got_err !== e || got_len !== l || rx_q.size() != 0) begin
      errors++; $display("FAIL empty got n=%0d err=%b len=%0d fwd=%0d exp n=1 err=%b len=%0d fwd=0",
                         got_done, got_err, got_len, rx_q.size(), e, l);
    end
  endtask

  task automatic test_align_timeout;
    bit acc; int fwd; logic [4:0] e; logic [15:0] l;
    model(31, 257, 1'b0, 1'b0, acc, fwd, e, l);
    send_frame(31, 257, 1'b0, 1'b0);
    checks++;
    if (got_done !== 1 || got_err !== e || got_len !== l) begin
      errors++; $display("FAIL align got n=%0d err=%b len=%0d exp n=1 err=%b len=%0d",
                         got_done, got_err, got_len, e, l);
    end
    model(31, 300, 1'b0, 1'b1, acc, fwd, e, l);
    send_frame(31, 300, 1'b0, 1'b1);
    checks++;
    if (got_done !== 1 || got_err !== e || got_len !== l) begin
      errors++; $display("FAIL timeout got n=%0d err=%b len=%0d exp n=1 err=%b len=%0d",
                         got_done, got_err, got_len, e, l);
    end
    checks++;
    if (done_cyc - fall_cyc != CRC_TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_delay got %0d exp %0d", done_cyc - fall_cyc, CRC_TIMEOUT + 1);
    end
  endtask

  task automatic test_random;
    bit acc; int fwd; logic [4:0] e; logic [15:0] l;
    int npre, nd; bit bad, stall;
    for (int k = 0; k < 8; k++) begin
      npre  = $urandom_range(34, 24);
      nd    = $urandom_range(600, 0);
      bad   = 1'($urandom_range(1, 0));
      stall = ($urandom_range(3, 0) == 0);
      model(npre, nd, bad, stall, acc, fwd, e, l);
      send_frame(npre, nd, bad, stall);
      checks++;
      if (got_done !== int'(acc) || rx_q.size() != fwd) begin
        errors++; $display("FAIL rand%0d_accept got n=%0d fwd=%0d exp n=%0d fwd=%0d",
                           k, got_done, rx_q.size(), acc, fwd);
      end
      if (acc) begin
        checks++;
        if (got_err !== e || got_len !== l || got_ok !== (e == 5'd0) || data_bad != 0) begin
          errors++; $display("FAIL rand%0d_status got ok=%b err=%b len=%0d bad=%0d exp err=%b len=%0d",
                             k, got_ok, got_err, got_len, data_bad, e, l);
        end
      end
    end
    checks++;
    if (mirror_bad != 0) begin errors++; $display("FAIL crc_mirror got %0d diffs exp 0", mirror_bad); end
  endtask

  initial begin
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00;
    test_reset();
    test_good_frame();
    test_crc_error();
    test_short_preamble();
    test_mid_reset();
    test_oversize_and_empty();
    test_align_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
